// File: rtl/dlx_mem_requester_if.sv
// Core-side request/response bundle of the DLX memory requester.
// The core is the master of this channel; the requester is the slave.
`timescale 1ns/1ps
interface dlx_mem_requester_if #(
    parameter int ADDRESS_SIZE = 16,
    parameter int WORD_SIZE    = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDRESS_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0]    req_wdata;
    logic                    rsp_valid;
    logic [WORD_SIZE-1:0]    rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dlx_mem_requester.sv
// Initiator of the DLX memory port: accepts one load/store at a time from the
// core, runs it against the responder with a bounded wait, returns a response.
`timescale 1ns/1ps
module dlx_mem_requester #(
    parameter int ADDRESS_SIZE   = 16,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    dlx_mem_requester_if.slave      core,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic                    ENABLE,
    output logic                    READNOTWRITE,
    inout  wire  [WORD_SIZE-1:0]    INOUT_DATA,
    input  logic                    DATA_READY
);

    // A disabled timeout still needs a one-bit counter to keep the code uniform.
    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  state_reg, state_next;
    logic                    enable_reg, enable_next;
    logic                    rnw_reg, rnw_next;
    logic [ADDRESS_SIZE-1:0] addr_reg, addr_next;
    logic [WORD_SIZE-1:0]    wdata_reg, wdata_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    req_ready_reg, req_ready_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [WORD_SIZE-1:0]    rsp_rdata_reg, rsp_rdata_next;
    logic                    rsp_err_reg, rsp_err_next;
    logic                    timeout_hit;
    logic                    cnt_sat;

    // The counter holds the number of completed wait cycles, so the abort fires
    // on the edge that would make it reach TIMEOUT_CYCLES.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign cnt_sat = (cnt_reg == CNT_W'(CNT_MAX));

    always_comb begin
        state_next     = state_reg;
        enable_next    = enable_reg;
        rnw_next       = rnw_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        cnt_next       = cnt_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;

        case (state_reg)
            S_IDLE: begin
                if (core.req_valid && req_ready_reg) begin
                    state_next  = S_ACCESS;
                    enable_next = 1'b1;
                    addr_next   = core.req_addr;
                    rnw_next    = ~core.req_we;
                    wdata_next  = core.req_wdata;
                    cnt_next    = '0;
                end
            end
            S_ACCESS: begin
                // Completion takes priority over a timeout landing on the same edge.
                if (DATA_READY) begin
                    state_next     = S_RESP;
                    enable_next    = 1'b0;
                    rsp_rdata_next = rnw_reg ? INOUT_DATA : '0;
                    rsp_err_next   = 1'b0;
                end else if (timeout_hit) begin
                    state_next     = S_RESP;
                    enable_next    = 1'b0;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                end else if (!cnt_sat) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_next  = S_IDLE;
                enable_next = 1'b0;
            end
            default: begin
                state_next  = S_IDLE;
                enable_next = 1'b0;
            end
        endcase

        // Handshake strobes are registered versions of where the FSM is heading.
        req_ready_next = (state_next == S_IDLE);
        rsp_valid_next = (state_next == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            enable_reg    <= 1'b0;
            rnw_reg       <= 1'b1;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            enable_reg    <= enable_next;
            rnw_reg       <= rnw_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            cnt_reg       <= cnt_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign ADDRESS      = addr_reg;
    assign ENABLE       = enable_reg;
    assign READNOTWRITE = rnw_reg;

    // Drive the shared data bus only while a store is in flight.
    assign INOUT_DATA = (enable_reg && !rnw_reg) ? wdata_reg : {WORD_SIZE{1'bz}};

    assign core.req_ready = req_ready_reg;
    assign core.rsp_valid = rsp_valid_reg;
    assign core.rsp_rdata = rsp_rdata_reg;
    assign core.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dlx_mem_requester.sv
// Bench for dlx_mem_requester: directed scenarios plus randomized accesses,
// checked against a transaction-level model of the memory port.
`timescale 1ns/1ps
module tb_dlx_mem_requester;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DATA_READY = 1'b0;
    logic          mem_drv = 1'b0;
    logic [DW-1:0] mem_data = '0;
    wire  [DW-1:0] INOUT_DATA;
    logic [AW-1:0] ADDRESS;
    logic          ENABLE;
    logic          READNOTWRITE;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int rsp_seen     = 0;
    int rsp_expected = 0;
    int txn_id       = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;
    rsp_t exp_q[$];

    assign INOUT_DATA = mem_drv ? mem_data : {DW{1'bz}};

    dlx_mem_requester_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW)) core_if ();

    dlx_mem_requester #(
        .ADDRESS_SIZE  (AW),
        .WORD_SIZE     (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core        (core_if.slave),
        .ADDRESS     (ADDRESS),
        .ENABLE      (ENABLE),
        .READNOTWRITE(READNOTWRITE),
        .INOUT_DATA  (INOUT_DATA),
        .DATA_READY  (DATA_READY)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response scoreboard: every rsp_valid pulse must match the oldest expected entry.
    initial begin
        logic prev_valid;
        rsp_t r;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (core_if.rsp_valid === 1'b1) begin
                check_eq("rsp_single_cycle", 64'(prev_valid), 64'(0));
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(core_if.rsp_valid), 64'(0));
                end else begin
                    r = exp_q.pop_front();
                    rsp_seen++;
                    check_eq("rsp_rdata", 64'(core_if.rsp_rdata), 64'(r.rdata));
                    check_eq("rsp_err", 64'(core_if.rsp_err), 64'(r.err));
                end
            end
            prev_valid = core_if.rsp_valid;
        end
    end

    // n = ENABLE cycle in which the responder raises DATA_READY (0 = never).
    // rst_at = ENABLE cycle in which reset is applied (0 = never).
    task automatic do_access(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input logic [DW-1:0] md,
                             input int n, input bit keep_valid, input int rst_at,
                             output int rise_cyc);
        int   k;
        int   e;
        int   exp_en;
        bit   exp_err;
        rsp_t r;
        exp_err = !(n >= 1 && n <= TO);
        exp_en  = exp_err ? TO : n;
        txn_id++;
        core_if.req_valid = 1'b1;
        core_if.req_we    = we;
        core_if.req_addr  = addr;
        core_if.req_wdata = wd;
        k = 0;
        while (core_if.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            check_eq("accept_wait_expired", 64'(core_if.req_ready), 64'(1));
            core_if.req_valid = 1'b0;
            rise_cyc = cyc;
            return;
        end
        @(negedge clk);
        if (!keep_valid) core_if.req_valid = 1'b0;
        rise_cyc = cyc;
        check_eq("req_ready_busy", 64'(core_if.req_ready), 64'(0));
        if (rst_at == 0) begin
            r.rdata = (!we && !exp_err) ? md : '0;
            r.err   = exp_err;
            exp_q.push_back(r);
            rsp_expected++;
        end
        e = 0;
        while (ENABLE === 1'b1 && e < 40) begin
            e++;
            check_eq("mem_address", 64'(ADDRESS), 64'(addr));
            check_eq("mem_rnw", 64'(READNOTWRITE), 64'(!we));
            if (we) check_eq("mem_wdata", 64'(INOUT_DATA), 64'(wd));
            if (e == rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                check_eq("reset_enable", 64'(ENABLE), 64'(0));
                check_eq("reset_ready_low", 64'(core_if.req_ready), 64'(0));
                check_eq("reset_no_rsp", 64'(core_if.rsp_valid), 64'(0));
                rst = 1'b1;
                @(negedge clk);
                check_eq("release_ready", 64'(core_if.req_ready), 64'(1));
                check_eq("release_no_rsp", 64'(core_if.rsp_valid), 64'(0));
                $display("[TB] txn %0d %s addr=%h reset in ENABLE cycle %0d",
                         txn_id, we ? "store" : "load", addr, rst_at);
                return;
            end
            if (e == n) begin
                DATA_READY = 1'b1;
                if (!we) begin
                    mem_drv  = 1'b1;
                    mem_data = md;
                end
            end
            @(negedge clk);
            DATA_READY = 1'b0;
            mem_drv    = 1'b0;
        end
        check_eq("enable_cycles", 64'(e), 64'(exp_en));
        check_eq("rsp_valid_timing", 64'(core_if.rsp_valid), 64'(1));
        $display("[TB] txn %0d %s addr=%h wdata=%h mem=%h ready_at=%0d enable_cycles=%0d err=%0d",
                 txn_id, we ? "store" : "load", addr, wd, md, n, e, exp_err);
    endtask

    initial begin
        int r1;
        int r2;
        int n;
        core_if.req_valid = 1'b0;
        core_if.req_we    = 1'b0;
        core_if.req_addr  = '0;
        core_if.req_wdata = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_enable", 64'(ENABLE), 64'(0));
        check_eq("reset_rnw", 64'(READNOTWRITE), 64'(1));
        check_eq("reset_address", 64'(ADDRESS), 64'(0));
        check_eq("reset_req_ready", 64'(core_if.req_ready), 64'(0));
        check_eq("reset_rsp_valid", 64'(core_if.rsp_valid), 64'(0));
        check_eq("reset_rsp_rdata", 64'(core_if.rsp_rdata), 64'(0));
        check_eq("reset_rsp_err", 64'(core_if.rsp_err), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check_eq("first_ready", 64'(core_if.req_ready), 64'(1));

        // Zero-wait load, then confirm the response data holds afterwards.
        do_access(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1, 1'b0, 0, r1);
        repeat (2) @(negedge clk);
        check_eq("rdata_hold", 64'(core_if.rsp_rdata), 64'(32'hDEADBEEF));

        // Store with three ENABLE cycles.
        do_access(1'b1, 16'h00A4, 32'h12345678, 32'h0, 3, 1'b0, 0, r1);
        @(negedge clk);

        // Timeout, then ready returns.
        do_access(1'b0, 16'h0033, 32'h0, 32'hCAFEF00D, 0, 1'b0, 0, r1);
        @(negedge clk);
        check_eq("ready_after_timeout", 64'(core_if.req_ready), 64'(1));

        // DATA_READY on the last allowed cycle wins over the timeout.
        do_access(1'b0, 16'h0044, 32'h0, 32'h0BADCAFE, TO, 1'b0, 0, r1);
        @(negedge clk);

        // Back-to-back loads with req_valid held.
        do_access(1'b0, 16'h0001, 32'h0, 32'h11111111, 2, 1'b1, 0, r1);
        do_access(1'b0, 16'h0002, 32'h0, 32'h22222222, 2, 1'b0, 0, r2);
        check_eq("b2b_spacing", 64'(r2 - r1), 64'(4));
        @(negedge clk);

        // Reset in the second ENABLE cycle of a store.
        do_access(1'b1, 16'h0055, 32'hA5A5A5A5, 32'h0, 0, 1'b0, 2, r1);

        // Spurious DATA_READY while idle.
        DATA_READY = 1'b1;
        @(negedge clk);
        DATA_READY = 1'b0;
        check_eq("spurious_enable", 64'(ENABLE), 64'(0));
        check_eq("spurious_ready", 64'(core_if.req_ready), 64'(1));
        check_eq("spurious_no_rsp", 64'(core_if.rsp_valid), 64'(0));
        do_access(1'b0, 16'h0066, 32'h0, 32'h66666666, 2, 1'b0, 0, r1);
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, TO + 2);
            do_access(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom,
                      n, (t != 39) && ($urandom_range(0, 2) == 0), 0, r1);
            if (core_if.req_valid === 1'b0 && $urandom_range(0, 3) == 0) begin
                DATA_READY = 1'b1;
                @(negedge clk);
                DATA_READY = 1'b0;
            end
        end
        core_if.req_valid = 1'b0;

        repeat (4) @(negedge clk);
        check_eq("rsp_queue_drained", 64'(exp_q.size()), 64'(0));
        check_eq("rsp_count", 64'(rsp_seen), 64'(rsp_expected));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dlx_mem_requester.md
Name: dlx_mem_requester

Overview:
- Initiator side of the DLX read/write memory port. It is the master that drives ADDRESS, ENABLE and READNOTWRITE and owns INOUT_DATA during writes.
- Accepts single word load/store requests from the core datapath through a valid/ready handshake.
- Runs one access at a time against the memory responder and waits on DATA_READY, with a bounded wait (timeout).
- Returns a one-cycle response (read data and error flag) to the core.

Parameters:
- ADDRESS_SIZE, 16, memory address width.
- WORD_SIZE, 32, data word width.
- TIMEOUT_CYCLES, 64, maximum ENABLE-high cycles before the access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  1  core request valid.
- req_ready  output  1  requester can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDRESS_SIZE  word address.
- req_wdata  input  WORD_SIZE  store data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  WORD_SIZE  load data; 0 for stores and errors.
- rsp_err  output  1  access timed out.
- ADDRESS  output  ADDRESS_SIZE  memory address.
- ENABLE  output  1  memory access enable.
- READNOTWRITE  output  1  1 = read, 0 = write.
- INOUT_DATA  inout  WORD_SIZE  bidirectional memory data.
- DATA_READY  input  1  memory completion.

Behaviour:
- Reset (rst=0 sampled at a rising edge): on that edge the state goes to IDLE and the outputs take these values:
  - ENABLE=0, READNOTWRITE=1, ADDRESS=0.
  - INOUT_DATA released (all Z).
  - req_ready=0 while rst=0; req_ready=1 on the first edge after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; the wait counter clears.
- All memory-side outputs are registered. INOUT_DATA is driven only when ENABLE=1 and READNOTWRITE=0; otherwise it is Z.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1: latch addr, we and wdata; go to ACCESS.
  - The same edge sets ENABLE=1, ADDRESS=addr and READNOTWRITE=~we.
  - Latency: ENABLE is visible in the cycle after acceptance.
- ACCESS:
  - req_ready=0. ENABLE, ADDRESS and READNOTWRITE are held stable; INOUT_DATA=wdata for stores.
  - The wait counter increments each cycle with DATA_READY=0.
  - DATA_READY=1 sampled: capture INOUT_DATA into rsp_rdata for loads, or load 0 for stores. Set rsp_err=0 and ENABLE=0, release INOUT_DATA, go to RESP.
  - Timeout: counter reaches TIMEOUT_CYCLES with DATA_READY still 0 (TIMEOUT_CYCLES>0). Then set ENABLE=0, rsp_rdata=0, rsp_err=1, go to RESP.
  - If DATA_READY=1 and timeout occur in the same cycle, DATA_READY wins and there is no error.
- RESP:
  - rsp_valid=1 for exactly one cycle; ENABLE=0; req_ready=0; go to IDLE.
  - rsp_rdata and rsp_err hold their values until the next response.
- ENABLE is low for at least 2 cycles between accesses: the RESP cycle plus the IDLE acceptance cycle.
- Throughput with a DATA_READY latency of L cycles after ENABLE rises: one access every L+3 cycles.
- DATA_READY while in IDLE or RESP is ignored and causes no state change.
- Reset during ACCESS: ENABLE drops and INOUT_DATA goes Z on the reset edge. No response is produced and the pending request is discarded.
- Counter width is clog2(TIMEOUT_CYCLES+1) and saturates; it clears on entry to ACCESS.
- No byte enables and no alignment check: addresses are word indices.

Test Plan:
1. Load, zero-wait responder. Drive req addr=0x0010, we=0; memory returns 0xDEADBEEF with DATA_READY in the first ENABLE cycle.
   -> ENABLE high for 1 cycle with READNOTWRITE=1; rsp_valid pulses 2 cycles after acceptance with rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Store, 3-cycle DATA_READY latency. Drive addr=0x00A4, wdata=0x12345678.
   -> INOUT_DATA=0x12345678 and READNOTWRITE=0 for all 3 ENABLE cycles; Z afterwards; rsp_rdata=0, rsp_err=0.
3. Timeout. TIMEOUT_CYCLES=4, no DATA_READY.
   -> ENABLE high exactly 4 cycles, then rsp_valid=1 with rsp_err=1, rsp_rdata=0; req_ready returns to 1.
4. Back-to-back. req_valid held high for two loads to 0x0001 and 0x0002, L=1.
   -> Second ENABLE rises 4 cycles after the first; ENABLE is low for 2 cycles between them; responses are in order.
5. Reset mid-access. Assert rst=0 during the 2nd ENABLE cycle of a store.
   -> ENABLE=0 and INOUT_DATA=Z on the next edge; no rsp_valid; req_ready=1 on the first edge after release.
6. Spurious DATA_READY. Pulse DATA_READY in IDLE.
   -> No rsp_valid and no state change; a following load completes normally.
